dma_controlador: RTL and testbench

Transfer engine that drives the one-word holding buffer of the DMA path from the other side: it takes a transfer descriptor (source, destination, word count) from the CPU, requests the bus, and moves words one at a time. Each word is read from memory, latched, and written to the destination. It is the initiator for both memory handshakes and reports completion back to the CPU with a one-cycle pulse.

---
 rtl/dma_controlador_if.sv | 28 ++
 rtl/dma_controlador.sv | 166 ++++++++++++++++
 tb/tb_dma_controlador.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_controlador_if.sv
// Bus-arbitration and memory-handshake bundle for dma_controlador.
// master: the DMA engine (drives requests, addresses and write data).
// slave : the CPU/memory side (drives grant, acks and read data).
interface dma_controlador_if #(
   parameter int ANCHO_DATOS = 32,
   parameter int ANCHO_DIR   = 8
);
   logic                   bus_req;
   logic                   bus_grant;
   logic                   lee_req;
   logic [ANCHO_DIR-1:0]   lee_dir;
   logic                   lee_ack;
   logic [ANCHO_DATOS-1:0] lee_datos;
   logic                   esc_req;
   logic [ANCHO_DIR-1:0]   esc_dir;
   logic [ANCHO_DATOS-1:0] esc_datos;
   logic                   esc_ack;

   modport master (
      output bus_req, lee_req, lee_dir, esc_req, esc_dir, esc_datos,
      input  bus_grant, lee_ack, lee_datos, esc_ack
   );

   modport slave (
      input  bus_req, lee_req, lee_dir, esc_req, esc_dir, esc_datos,
      output bus_grant, lee_ack, lee_datos, esc_ack
   );
endinterface

// File: rtl/dma_controlador.sv
// dma_controlador: word-at-a-time DMA transfer engine.
// Takes a descriptor (source, destination, count), requests the bus, then
// for each word reads memory, latches the word and writes it out.
// Optional feature macro: DMA_TIMEOUT_EN -- adds an 8-bit watchdog that
// aborts a transfer (error pulse) after 255 cycles waiting on an ack.
module dma_controlador #(
   parameter int ANCHO_DATOS = 32,
   parameter int ANCHO_DIR   = 8,
   parameter int ANCHO_CONT  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inicio,
   input  logic [ANCHO_DIR-1:0]  dir_origen,
   input  logic [ANCHO_DIR-1:0]  dir_destino,
   input  logic [ANCHO_CONT-1:0] cantidad,
   output logic                  ocupado,
   output logic                  listo,
   output logic                  error,
   output logic [ANCHO_CONT-1:0] transferidas,
   dma_controlador_if.master     bus
);

   typedef enum logic [2:0] {
      REPOSO,
      PIDE_BUS,
      LEE,
      ESCRIBE,
      FIN
   } estado_t;

   estado_t                estado;
   estado_t                estado_sig;
   logic [ANCHO_DIR-1:0]   origen;
   logic [ANCHO_DIR-1:0]   destino;
   logic [ANCHO_CONT-1:0]  restante;
   logic [ANCHO_DATOS-1:0] dato;
   logic                   expira;   // watchdog fires on this edge

   // State register.
   // NOTE: reset is synchronous and active-high, so it lives inside the
   // clocked branch rather than in the sensitivity list.
   always_ff @(posedge clk) begin
      if (reset) estado <= REPOSO;
      else       estado <= estado_sig;
   end

   // Next-state decode and per-state handshake outputs.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path
      // leaves one unassigned, which would otherwise infer a latch.
      estado_sig  = estado;
      ocupado     = 1'b0;
      listo       = 1'b0;
      bus.bus_req = 1'b0;
      bus.lee_req = 1'b0;
      bus.esc_req = 1'b0;
      unique case (estado)
         REPOSO: begin
            if (inicio)
               estado_sig = (cantidad == '0) ? FIN : PIDE_BUS;
         end
         PIDE_BUS: begin
            ocupado     = 1'b1;
            bus.bus_req = 1'b1;
            if (bus.bus_grant) estado_sig = LEE;
         end
         LEE: begin
            ocupado     = 1'b1;
            bus.bus_req = 1'b1;
            bus.lee_req = 1'b1;
            if (bus.lee_ack)  estado_sig = ESCRIBE;
            else if (expira)  estado_sig = REPOSO;
         end
         ESCRIBE: begin
            ocupado     = 1'b1;
            bus.bus_req = 1'b1;
            bus.esc_req = 1'b1;
            if (bus.esc_ack) begin
               // Grant is only re-examined here, at the word boundary.
               if (restante == ANCHO_CONT'(1)) estado_sig = FIN;
               else if (bus.bus_grant)         estado_sig = LEE;
               else                            estado_sig = PIDE_BUS;
            end else if (expira) begin
               estado_sig = REPOSO;
            end
         end
         FIN: begin
            listo      = 1'b1;
            estado_sig = REPOSO;
         end
         default: estado_sig = REPOSO;
      endcase
   end

   // Addresses and data come straight from registers, so they stay stable
   // for as long as the matching request is held.
   assign bus.lee_dir   = origen;
   assign bus.esc_dir   = destino;
   assign bus.esc_datos = dato;

   // Descriptor, word latch and progress counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         origen       <= '0;
         destino      <= '0;
         restante     <= '0;
         dato         <= '0;
         transferidas <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         unique case (estado)
            REPOSO: begin
               if (inicio) begin
                  origen       <= dir_origen;
                  destino      <= dir_destino;
                  restante     <= cantidad;
                  transferidas <= '0;
               end
            end
            LEE: begin
               if (bus.lee_ack) dato <= bus.lee_datos;
            end
            ESCRIBE: begin
               if (bus.esc_ack) begin
                  origen       <= origen + ANCHO_DIR'(1);
                  destino      <= destino + ANCHO_DIR'(1);
                  restante     <= restante - ANCHO_CONT'(1);
                  transferidas <= transferidas + ANCHO_CONT'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef DMA_TIMEOUT_EN
   logic [7:0] vigia;
   logic       error_q;

   // The 255th consecutive stalled cycle is the one where vigia reads 254.
   assign expira = (vigia == 8'd254) &&
                   (((estado == LEE)     && !bus.lee_ack) ||
                    ((estado == ESCRIBE) && !bus.esc_ack));
   assign error  = error_q;

   // Watchdog: counts stalled handshake cycles, cleared on any state change.
   always_ff @(posedge clk) begin
      if (reset) begin
         vigia   <= '0;
         error_q <= 1'b0;
      end else begin
         error_q <= expira;
         if ((estado_sig != estado) || !((estado == LEE) || (estado == ESCRIBE)))
            vigia <= '0;
         else
            vigia <= vigia + 8'd1;
      end
   end
`else
   assign expira = 1'b0;
   assign error  = 1'b0;
`endif

endmodule

// File: tb/tb_dma_controlador.sv
// Self-checking bench for dma_controlador: a transaction-level model of the
// transfer (words done, read/write pending, waiting for grant) predicts every
// output each cycle; directed cases pin latency, address wrap and counts.
module tb_dma_controlador;

   logic       clk = 1'b0;
   logic       reset;
   logic       inicio;
   logic [7:0] dir_origen;
   logic [7:0] dir_destino;
   logic [7:0] cantidad;
   logic       ocupado;
   logic       listo;
   logic       error;
   logic [7:0] transferidas;

   dma_controlador_if #(.ANCHO_DATOS(32), .ANCHO_DIR(8)) bus ();

   dma_controlador #(.ANCHO_DATOS(32), .ANCHO_DIR(8), .ANCHO_CONT(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .inicio       (inicio),
      .dir_origen   (dir_origen),
      .dir_destino  (dir_destino),
      .cantidad     (cantidad),
      .ocupado      (ocupado),
      .listo        (listo),
      .error        (error),
      .transferidas (transferidas),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int ciclo = 0;

   always @(posedge clk) ciclo <= ciclo + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ciclo);
      end
   endtask

   // Memory image and responder controls.
   logic [31:0] mem [256];
   bit rnd_ack, rnd_grant, force_low, no_lee, no_esc;

   // Responder: drives grant, acks and read data 1 time unit after each edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         bus.bus_grant = force_low ? 1'b0 : (rnd_grant ? ($urandom_range(0, 3) != 0) : 1'b1);
         bus.lee_ack   = no_lee ? 1'b0 : (rnd_ack ? ($urandom_range(0, 2) != 0) : 1'b1);
         bus.esc_ack   = no_esc ? 1'b0 : (rnd_ack ? ($urandom_range(0, 2) != 0) : 1'b1);
         bus.lee_datos = bus.lee_req ? mem[bus.lee_dir] : $urandom();
      end
   end

   // Transaction-level model state.
   bit         m_busy, m_fin, m_err, m_need, m_have;
   logic [7:0] m_src, m_dst, m_n, m_words;
   int         m_stall;
   logic [7:0] rd_log[$];
   logic [7:0] wr_log[$];
   bit         bus_seen;

   // Compare process: check outputs mid-cycle, then advance the model with
   // the inputs the DUT will sample at the coming edge.
   always @(negedge clk) begin
      logic       exp_lee, exp_esc, fin_now;
      logic [7:0] idx;
      exp_lee = m_busy && !m_need && !m_have;
      exp_esc = m_busy && m_have;
      check("ocupado", ocupado, m_busy);
      check("bus_req", bus.bus_req, m_busy);
      check("listo", listo, m_fin);
      check("error", error, m_err);
      check("lee_req", bus.lee_req, exp_lee);
      check("esc_req", bus.esc_req, exp_esc);
      check("transferidas", transferidas, m_words);
      idx = m_src + m_words;
      if (exp_lee) check("lee_dir", bus.lee_dir, idx);
      if (exp_esc) begin
         check("esc_dir", bus.esc_dir, 8'(m_dst + m_words));
         check("esc_datos", bus.esc_datos, mem[idx]);
      end
      if (bus.bus_req === 1'b1) bus_seen = 1'b1;
      if (!reset && bus.lee_req === 1'b1 && bus.lee_ack) rd_log.push_back(bus.lee_dir);
      if (!reset && bus.esc_req === 1'b1 && bus.esc_ack) wr_log.push_back(bus.esc_dir);

      if (reset) begin
         m_busy = 0; m_fin = 0; m_err = 0; m_need = 0; m_have = 0;
         m_words = '0; m_src = '0; m_dst = '0; m_n = '0; m_stall = 0;
      end else begin
         fin_now = m_fin;
         m_fin = 0;
         m_err = 0;
         if (m_busy) begin
            if (m_need) begin
               if (bus.bus_grant) begin m_need = 0; m_stall = 0; end
            end else if (!m_have) begin
               if (bus.lee_ack) begin m_have = 1; m_stall = 0; end
               else m_stall++;
            end else if (bus.esc_ack) begin
               m_words = m_words + 8'd1;
               m_have  = 0;
               m_stall = 0;
               if (m_words == m_n) begin m_busy = 0; m_fin = 1; end
               else m_need = !bus.bus_grant;
            end else begin
               m_stall++;
            end
`ifdef DMA_TIMEOUT_EN
            if (m_busy && m_stall == 255) begin
               m_busy = 0; m_err = 1; m_have = 0; m_need = 0; m_stall = 0;
            end
`endif
         end else if (!fin_now && inicio) begin
            m_src = dir_origen; m_dst = dir_destino; m_n = cantidad; m_words = '0;
            if (cantidad == 8'd0) m_fin = 1;
            else begin m_busy = 1; m_need = 1; m_have = 0; m_stall = 0; end
         end
      end
   end

   int t_inicio;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic start(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
      dir_origen  = s;
      dir_destino = d;
      cantidad    = n;
      inicio      = 1'b1;
      t_inicio    = ciclo;
      tick();
      inicio      = 1'b0;
   endtask

   task automatic wait_listo(input int budget);
      int n = 0;
      while (listo !== 1'b1 && n < budget) begin tick(); n++; end
      check("wait_listo", listo, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] s, d, n;
      for (int i = 0; i < 256; i++) mem[i] = $urandom();
      reset = 1'b1; inicio = 1'b0; dir_origen = '0; dir_destino = '0; cantidad = '0;
      bus.bus_grant = 1'b1; bus.lee_ack = 1'b1; bus.esc_ack = 1'b1; bus.lee_datos = '0;
      rnd_ack = 0; rnd_grant = 0; force_low = 0; no_lee = 0; no_esc = 0;

      // Reset held with grant and acks high: nothing may move.
      bus_seen = 0;
      repeat (10) tick();
      check("rst_bus_req", bus.bus_req, 1'b0);
      check("rst_lee_req", bus.lee_req, 1'b0);
      check("rst_esc_req", bus.esc_req, 1'b0);
      check("rst_transferidas", transferidas, 8'd0);
      check("rst_bus_seen", bus_seen, 1'b0);
      reset = 1'b0;
      tick();

      // Three words, zero-wait: listo 8 cycles after inicio.
      rd_log.delete(); wr_log.delete();
      start(8'h10, 8'h80, 8'd3);
      wait_listo(50);
      check("t1_latency", ciclo - t_inicio, 8);
      check("t1_transferidas", transferidas, 8'd3);
      check("t1_nrd", rd_log.size(), 3);
      check("t1_nwr", wr_log.size(), 3);
      for (int i = 0; i < 3 && i < wr_log.size() && i < rd_log.size(); i++) begin
         check("t1_rd_addr", rd_log[i], 8'h10 + i);
         check("t1_wr_addr", wr_log[i], 8'h80 + i);
      end
      tick();

      // Address wrap.
      rd_log.delete(); wr_log.delete();
      start(8'hFF, 8'hFE, 8'd2);
      wait_listo(50);
      check("t2_nwr", wr_log.size(), 2);
      if (rd_log.size() == 2 && wr_log.size() == 2) begin
         check("t2_rd0", rd_log[0], 8'hFF);
         check("t2_rd1", rd_log[1], 8'h00);
         check("t2_wr0", wr_log[0], 8'hFE);
         check("t2_wr1", wr_log[1], 8'hFF);
      end
      tick();

      // Zero-length descriptor.
      bus_seen = 0;
      start(8'h33, 8'h44, 8'd0);
      wait_listo(5);
      check("t3_latency", ciclo - t_inicio, 1);
      tick();
      check("t3_bus_seen", bus_seen, 1'b0);
      check("t3_transferidas", transferidas, 8'd0);

      // Grant drop at a word boundary plus an ignored second inicio.
      wr_log.delete();
      start(8'h20, 8'h40, 8'd4);
      for (int i = 0; i < 50 && wr_log.size() < 1; i++) tick();
      force_low = 1;
      tick();
      dir_origen = 8'hAA; dir_destino = 8'hBB; cantidad = 8'd9; inicio = 1'b1;
      tick();
      inicio = 1'b0;
      repeat (3) tick();
      check("t4_drop_bus_req", bus.bus_req, 1'b1);
      check("t4_drop_lee_req", bus.lee_req, 1'b0);
      check("t4_drop_nwr", wr_log.size(), 2);
      force_low = 0;
      wait_listo(50);
      check("t4_nwr", wr_log.size(), 4);
      if (wr_log.size() == 4) check("t4_wr3", wr_log[3], 8'h43);
      check("t4_transferidas", transferidas, 8'd4);
      tick();

      // Reset while a write is waiting for its ack.
      no_esc = 1;
      start(8'h50, 8'h60, 8'd3);
      for (int i = 0; i < 20 && bus.esc_req !== 1'b1; i++) tick();
      check("t5_in_escribe", bus.esc_req, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t5_esc_req", bus.esc_req, 1'b0);
      check("t5_bus_req", bus.bus_req, 1'b0);
      check("t5_listo", listo, 1'b0);
      check("t5_error", error, 1'b0);
      no_esc = 0;
      tick();

`ifdef DMA_TIMEOUT_EN
      // Read never acknowledged: watchdog abort.
      no_lee = 1;
      start(8'h05, 8'h06, 8'd2);
      for (int i = 0; i < 20 && bus.lee_req !== 1'b1; i++) tick();
      t_inicio = ciclo;
      for (int i = 0; i < 300 && error !== 1'b1; i++) tick();
      check("t6_error", error, 1'b1);
      check("t6_delay", ciclo - t_inicio, 255);
      check("t6_listo", listo, 1'b0);
      tick();
      check("t6_ocupado", ocupado, 1'b0);
      check("t6_transferidas", transferidas, 8'd0);
      no_lee = 0;
      tick();
`endif

      // Randomized transfers with random acks, grants and disturbances.
      rnd_ack = 1; rnd_grant = 1;
      for (int t = 0; t < 30; t++) begin
         s = 8'($urandom()); d = 8'($urandom()); n = 8'($urandom_range(0, 6));
         start(s, d, n);
         if ($urandom_range(0, 7) == 0) begin
            repeat ($urandom_range(0, 5)) tick();
            reset = 1'b1;
            tick();
            reset = 1'b0;
            tick();
         end else begin
            if (n != 0 && $urandom_range(0, 3) == 0) begin
               dir_origen = 8'($urandom()); cantidad = 8'($urandom()); inicio = 1'b1;
               tick();
               inicio = 1'b0;
            end
            wait_listo(400);
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
